peri_write_buffer: RTL
======================

PERI_WRITE_BUFFER -- requirements
Module: peri_write_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO entry count; legal values are powers of two from 2 to 64.
REQ-003 Parameter AW, default 16, SHALL set the peripheral address width.
REQ-004 Parameter DW, default 16, SHALL set the peripheral data width.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port peri_web, input, 1 bit: peripheral write strobe from the core, active low.
REQ-008 Port peri_addr, input, AW bits: peripheral write address.
REQ-009 Port peri_datao, input, DW bits: peripheral write data.
REQ-010 Port out_valid, output, 1 bit: head entry available.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-012 Port out_addr, output, AW bits: head entry address.
REQ-013 Port out_data, output, DW bits: head entry data.
REQ-014 Port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-015 Port full, output, 1 bit: count equals DEPTH.
REQ-016 Port overflow, output, 1 bit: sticky flag, set when a write was dropped.
REQ-017 Port drop_cnt, output, 8 bits: saturating count of dropped writes.
REQ-018 Port clr_ovf, input, 1 bit: synchronous clear of overflow and drop_cnt.

Function
REQ-019 A push request SHALL exist in any cycle where peri_web is 0 at the rising edge of clk; {peri_addr, peri_datao} SHALL be sampled at that edge.
REQ-020 A pop SHALL occur at an edge where out_valid and out_ready are both 1.
REQ-021 The FIFO SHALL be first-word-fall-through: out_addr and out_data SHALL show the head entry combinationally from storage; out_valid SHALL equal (count != 0).
REQ-022 out_addr and out_data SHALL hold their last value while out_valid is 0; this value is don't-care for checking.
REQ-023 A push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-024 On a simultaneous accepted push and pop, count SHALL be unchanged, the head SHALL advance and the new entry SHALL append at the tail.
REQ-025 A push on an empty FIFO SHALL make out_valid 1 in the next cycle; minimum latency is 1 cycle.
REQ-026 A push that is not accepted SHALL be dropped, FIFO contents SHALL be unchanged, overflow SHALL be set to 1, and drop_cnt SHALL increment with saturation at 255.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH with no gap.
REQ-028 count SHALL be +1 on push-only, -1 on pop-only, and unchanged otherwise.
REQ-029 full SHALL equal (count == DEPTH).
REQ-030 clr_ovf=1 SHALL clear overflow and drop_cnt at the next edge.
REQ-031 If clr_ovf and a drop occur in the same cycle, overflow SHALL be 1 and drop_cnt SHALL be 1.
REQ-032 A pop with out_valid=0 SHALL have no effect.

Reset
REQ-033 While rst is 1, asynchronously: pointers=0, count=0, out_valid=0, full=0, overflow=0, drop_cnt=0, out_addr=0, out_data=0.
REQ-034 Storage contents SHALL NOT require reset.
REQ-035 Reset mid-operation SHALL discard all entries.
REQ-036 The first edge after rst falls SHALL accept a push normally.

Verification
REQ-037 Single write: peri_web=0 for one cycle with addr 0x0010, data 0xBEEF, out_ready=0 -> next cycle out_valid=1, out_addr=0x0010, out_data=0xBEEF, count=1.
REQ-038 Fill and overflow with DEPTH=8: 9 consecutive writes with data 1..9 and out_ready=0 -> count=8, full=1, overflow=1, drop_cnt=1; draining yields data 1..8 in order.
REQ-039 Full with simultaneous push/pop: FIFO full with 1..8, write 9 with out_ready=1 -> no drop, count=8, drain order 2..9.
REQ-040 Wrap-around: 20 writes interleaved with pops, occupancy kept between 1 and 3 -> all 20 entries emerge in order and uncorrupted.
REQ-041 Saturation and clear: 300 drops -> drop_cnt=255; then clr_ovf=1 with a drop in the same cycle -> overflow=1, drop_cnt=1.
REQ-042 Reset mid-stream: rst pulsed asynchronously with count=5 -> out_valid=0 and count=0 immediately; the next write appears as the sole entry.

Source files
------------

// File: rtl/peri_write_buffer.sv
// Posted-write FIFO between the core's peripheral write strobe and a ready/valid consumer.
// First-word-fall-through head, with drop accounting when writes arrive while full.
module peri_write_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     peri_web,
  input  logic [AW-1:0]            peri_addr,
  input  logic [DW-1:0]            peri_datao,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_addr,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] last_data_q, last_data_d;

  logic push_req, push_acc, pop, drop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == DepthCnt);
    push_req  = ~peri_web;
    pop       = out_valid & out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    push_acc  = push_req & (~full | pop);
    drop      = push_req & ~push_acc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear applies first so a same-cycle drop is still recorded.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  // Outputs track the head while valid and freeze on the last shown entry once empty.
  always_comb begin
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (out_valid) begin
      last_addr_d = head_addr;
      last_data_d = head_data;
    end
  end

  assign out_addr = out_valid ? head_addr : last_addr_q;
  assign out_data = out_valid ? head_data : last_data_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= 8'd0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      addr_mem[wr_ptr_q] <= peri_addr;
      data_mem[wr_ptr_q] <= peri_datao;
    end
  end

endmodule
